apb_slave_regfile: RTL and testbench

APB3 completer with a parameterised register file; the responder counterpart to the team's `apb_master`, sitting on the same `psel`/`penable`/`pready` bus. It decodes word-aligned addresses, inserts a programmable number of wait states and performs reads and writes. It flags `pslverr` for illegal accesses and exposes all register contents as a flat bus to downstream fabric.

---
 rtl/apb_slave_regfile_pkg.sv | 26 ++
 rtl/apb_slave_regfile_if.sv | 24 ++
 rtl/apb_wait_counter.sv | 26 ++
 rtl/apb_slave_regfile.sv | 147 ++++++++++++++
 tb/tb_apb_slave_regfile.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/apb_slave_regfile_pkg.sv
// Shared encodings for the APB register-file completer: FSM states, error causes
// and the default identification word.
package apb_slave_regfile_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } apb_state_e;

    // Debug-only cause of a pslverr response; the bus itself sees one bit.
    typedef enum logic [1:0] {
        APB_ERR_NONE      = 2'd0,
        APB_ERR_UNALIGNED = 2'd1,
        APB_ERR_RANGE     = 2'd2,
        APB_ERR_RO_WRITE  = 2'd3
    } apb_err_e;

    localparam logic [31:0] APB_ID_VALUE = 32'hA9B0_0001;
    localparam int          APB_CNT_W    = 4;

    function automatic logic apb_is_err(input apb_err_e cause);
        return cause != APB_ERR_NONE;
    endfunction

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB3 bus bundle shared by a master and the register-file completer.
interface apb_slave_regfile_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_wait_counter.sv
// Loadable down-counter; done marks the final wait cycle (count == 1).
module apb_wait_counter #(
    parameter int WIDTH = 4
) (
    input  logic             pclock,
    input  logic             presetn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             done
);

    always_ff @(posedge pclock or negedge presetn) begin
        if (!presetn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == WIDTH'(1));

endmodule

// File: rtl/apb_slave_regfile.sv
// APB3 completer with a word register file, programmable wait states and
// pslverr on unaligned, out-of-range or read-only accesses.
module apb_slave_regfile
    import apb_slave_regfile_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 16,
    parameter int                    WAIT_CYCLES = 0,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = DATA_WIDTH'(APB_ID_VALUE)
) (
    input  logic                           pclock,
    input  logic                           presetn,
    apb_slave_regfile_if.slave             bus,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat
);

    localparam int                    IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH-1:0] REG_SPAN = ADDR_WIDTH'(4 * NUM_REGS);

    typedef struct packed {
        logic                  write;
        logic [IDX_W-1:0]      idx;
        logic [DATA_WIDTH-1:0] wdata;
        apb_err_e              err;
    } req_t;

    apb_state_e                           state;
    req_t                                 req;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs;
    logic [DATA_WIDTH-1:0]                prdata_q;
    logic                                 pready_q;
    logic                                 pslverr_q;

    logic                  setup;
    logic [IDX_W-1:0]      dec_idx;
    apb_err_e              dec_err;
    logic [IDX_W-1:0]      rd_idx;
    logic                  rd_blank;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  commit;
    logic [APB_CNT_W-1:0]  cnt;
    logic                  cnt_done;

    assign setup   = bus.psel && !bus.penable;
    assign dec_idx = bus.paddr[IDX_W+1:2];

    // Priority only affects the debug cause; any hit raises pslverr.
    always_comb begin
        dec_err = APB_ERR_NONE;
        if (bus.paddr[1:0] != 2'b00)
            dec_err = APB_ERR_UNALIGNED;
        else if (bus.paddr >= REG_SPAN)
            dec_err = APB_ERR_RANGE;
        else if (bus.pwrite && dec_idx == '0)
            dec_err = APB_ERR_RO_WRITE;
    end

    // With no wait states RESP is entered straight from the setup phase, so
    // the read has to be resolved from the live bus instead of the capture.
    always_comb begin
        if (state == IDLE) begin
            rd_idx   = dec_idx;
            rd_blank = bus.pwrite || apb_is_err(dec_err);
        end else begin
            rd_idx   = req.idx;
            rd_blank = req.write || apb_is_err(req.err);
        end
        rd_data = rd_blank ? '0 : regs[rd_idx];
    end

    assign commit = (state == RESP) && bus.psel && bus.penable && bus.pwrite &&
                    req.write && !apb_is_err(req.err);

    apb_wait_counter #(
        .WIDTH(APB_CNT_W)
    ) u_wait (
        .pclock  (pclock),
        .presetn (presetn),
        .load    ((state == IDLE) && setup),
        .load_val(APB_CNT_W'(WAIT_CYCLES)),
        .dec     ((state == WAIT) && !cnt_done && (cnt != '0)),
        .count   (cnt),
        .done    (cnt_done)
    );

    always_ff @(posedge pclock or negedge presetn) begin
        if (!presetn) begin
            state     <= IDLE;
            req       <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            case (state)
                IDLE: begin
                    if (setup) begin
                        req <= '{write: bus.pwrite, idx: dec_idx,
                                 wdata: bus.pwdata, err: dec_err};
                        if (WAIT_CYCLES == 0) begin
                            state     <= RESP;
                            pready_q  <= 1'b1;
                            pslverr_q <= apb_is_err(dec_err);
                            prdata_q  <= rd_data;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!bus.psel) begin
                        state <= IDLE;
                    end else if (cnt_done && bus.penable) begin
                        state     <= RESP;
                        pready_q  <= 1'b1;
                        pslverr_q <= apb_is_err(req.err);
                        prdata_q  <= rd_data;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign regs[0] = ID_VALUE;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
        logic [DATA_WIDTH-1:0] q;
        always_ff @(posedge pclock or negedge presetn) begin
            if (!presetn)
                q <= '0;
            else if (commit && req.idx == IDX_W'(r))
                q <= req.wdata;
        end
        assign regs[r] = q;
    end

    assign regs_flat   = regs;
    assign bus.pready  = pready_q;
    assign bus.pslverr = pslverr_q;
    assign bus.prdata  = prdata_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: three instances (0, 3 and 4 wait states) share
// one bus driver; expected responses are queued at setup and checked at pready.
module tb_apb_slave_regfile;

    localparam logic [31:0] ID = 32'hA9B0_0001;

    typedef struct {
        bit          err;
        logic [31:0] rdata;
        int          waits;
    } exp_t;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          err;
        logic [31:0] rdata;
    } vec_t;

    logic        pclock = 1'b0;
    logic        presetn;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [1:0]  dut_sel;

    logic         rdy, err;
    logic [31:0]  rdata;
    logic [511:0] flat, flat0, flat1, flat2;

    int n_pass  = 0;
    int n_total = 0;

    exp_t        sb[$];
    vec_t        vecs[$];
    logic [31:0] model [3][16];

    always #5 pclock = ~pclock;

    apb_slave_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
    apb_slave_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();
    apb_slave_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus2 ();

    assign bus0.psel = psel && dut_sel == 2'd0;
    assign bus1.psel = psel && dut_sel == 2'd1;
    assign bus2.psel = psel && dut_sel == 2'd2;
    assign bus0.penable = penable; assign bus0.pwrite = pwrite;
    assign bus0.paddr   = paddr;   assign bus0.pwdata = pwdata;
    assign bus1.penable = penable; assign bus1.pwrite = pwrite;
    assign bus1.paddr   = paddr;   assign bus1.pwdata = pwdata;
    assign bus2.penable = penable; assign bus2.pwrite = pwrite;
    assign bus2.paddr   = paddr;   assign bus2.pwdata = pwdata;

    apb_slave_regfile #(.WAIT_CYCLES(0)) dut0 (
        .pclock(pclock), .presetn(presetn), .bus(bus0), .regs_flat(flat0));
    apb_slave_regfile #(.WAIT_CYCLES(3)) dut1 (
        .pclock(pclock), .presetn(presetn), .bus(bus1), .regs_flat(flat1));
    apb_slave_regfile #(.WAIT_CYCLES(4)) dut2 (
        .pclock(pclock), .presetn(presetn), .bus(bus2), .regs_flat(flat2));

    always_comb begin
        rdy = bus0.pready; err = bus0.pslverr; rdata = bus0.prdata; flat = flat0;
        if (dut_sel == 2'd1) begin
            rdy = bus1.pready; err = bus1.pslverr; rdata = bus1.prdata; flat = flat1;
        end else if (dut_sel == 2'd2) begin
            rdy = bus2.pready; err = bus2.pslverr; rdata = bus2.prdata; flat = flat2;
        end
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_flat(input string name);
        logic [511:0] exp;
        for (int r = 0; r < 16; r++) exp[r*32 +: 32] = model[dut_sel][r];
        n_total++;
        if (flat === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, flat, exp);
    endtask

    task automatic reset_model();
        for (int k = 0; k < 3; k++)
            for (int r = 0; r < 16; r++) model[k][r] = (r == 0) ? ID : 32'h0;
    endtask

    // Called and returns on a falling edge; b2b leaves psel high so the next
    // call's setup directly follows this access phase.
    task automatic xfer(input string name, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input bit exp_err,
                        input logic [31:0] exp_rdata, input int exp_waits, input bit b2b);
        exp_t e;
        int   waits;
        bit   quiet;
        sb.push_back('{exp_err, exp_rdata, exp_waits});
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        @(negedge pclock);
        penable = 1'b1;
        waits = 0;
        quiet = 1'b1;
        while (!rdy && waits < 40) begin
            if (rdata != 32'h0 || err) quiet = 1'b0;
            @(negedge pclock);
            waits++;
        end
        e = sb.pop_front();
        check32({name, "_waits"}, 32'(waits), 32'(e.waits));
        check32({name, "_pslverr"}, 32'(err), 32'(e.err));
        check32({name, "_prdata"}, rdata, e.rdata);
        if (e.waits > 0) check32({name, "_quiet_wait"}, 32'(quiet), 32'd1);
        if (wr && !e.err) model[dut_sel][addr[5:2]] = data;
        @(negedge pclock);
        check32({name, "_pready_drop"}, 32'(rdy), 32'd0);
        check_flat({name, "_flat"});
        if (!b2b) begin
            psel = 1'b0; penable = 1'b0;
            @(negedge pclock);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; dut_sel = 2'd0;
        reset_model();
        repeat (2) @(negedge pclock);
        check32("rst_pready", 32'(rdy), 32'd0);
        check32("rst_pslverr", 32'(err), 32'd0);
        check32("rst_prdata", rdata, 32'h0);
        check_flat("rst_flat0");
        presetn = 1'b1;
        @(negedge pclock);

        // Zero-wait-state instance: function, errors and boundaries.
        vecs.push_back('{1'b1, 32'h04, 32'h1234_5678, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'h04, 32'h0,         1'b0, 32'h1234_5678});
        vecs.push_back('{1'b1, 32'h00, 32'hFFFF_FFFF, 1'b1, 32'h0});
        vecs.push_back('{1'b1, 32'h42, 32'hCAFE_0001, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 32'h40, 32'h0,         1'b1, 32'h0});
        vecs.push_back('{1'b0, 32'h05, 32'h0,         1'b1, 32'h0});
        vecs.push_back('{1'b0, 32'h00, 32'h0,         1'b0, ID});
        vecs.push_back('{1'b0, 32'h04, 32'h0,         1'b0, 32'h1234_5678});
        vecs.push_back('{1'b1, 32'h3C, 32'hDEAD_BEEF, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'h3C, 32'h0,         1'b0, 32'hDEAD_BEEF});
        vecs.push_back('{1'b1, 32'h1000_0004, 32'h1, 1'b1, 32'h0});
        for (int i = 0; i < vecs.size(); i++)
            xfer($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                 vecs[i].err, vecs[i].rdata, 0, 1'b0);
        check32("flat_reg1", flat[63:32], 32'h1234_5678);

        // Back-to-back writes: ACCESS goes straight to the next SETUP.
        xfer("b2b_w08", 1'b1, 32'h08, 32'hAAAA_5555, 1'b0, 32'h0, 0, 1'b1);
        xfer("b2b_w0c", 1'b1, 32'h0C, 32'h0BAD_F00D, 1'b0, 32'h0, 0, 1'b1);
        xfer("b2b_r08", 1'b0, 32'h08, 32'h0, 1'b0, 32'hAAAA_5555, 0, 1'b1);
        xfer("b2b_r0c", 1'b0, 32'h0C, 32'h0, 1'b0, 32'h0BAD_F00D, 0, 1'b0);

        // Three wait states.
        dut_sel = 2'd1;
        xfer("w3_id",  1'b0, 32'h00, 32'h0, 1'b0, ID, 3, 1'b0);
        xfer("w3_wr",  1'b1, 32'h10, 32'h5A5A_0F0F, 1'b0, 32'h0, 3, 1'b0);
        xfer("w3_rd",  1'b0, 32'h10, 32'h0, 1'b0, 32'h5A5A_0F0F, 3, 1'b0);
        xfer("w3_err", 1'b1, 32'h00, 32'h1, 1'b1, 32'h0, 3, 1'b0);

        // Four wait states: master abandons the write in the 2nd wait cycle.
        dut_sel = 2'd2;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h14; pwdata = 32'h55AA_55AA;
        @(negedge pclock);
        penable = 1'b1;
        @(negedge pclock);
        psel = 1'b0; penable = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge pclock);
            if (rdy) seen = 1'b1;
        end
        check32("abort_no_pready", 32'(seen), 32'd0);
        check_flat("abort_flat");
        xfer("abort_rd", 1'b0, 32'h14, 32'h0, 1'b0, 32'h0, 4, 1'b0);

        // Reset asserted while a write sits in its response cycle.
        dut_sel = 2'd0;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'h7777_7777;
        @(negedge pclock);
        penable = 1'b1;
        check32("rst_mid_pready_pre", 32'(rdy), 32'd1);
        #2 presetn = 1'b0;
        #1;
        check32("rst_async_pready", 32'(rdy), 32'd0);
        reset_model();
        check_flat("rst_async_flat");
        @(negedge pclock);
        psel = 1'b0; penable = 1'b0; presetn = 1'b1;
        @(negedge pclock);
        check_flat("rst_post_flat");
        xfer("rst_rd20", 1'b0, 32'h20, 32'h0, 1'b0, 32'h0, 0, 1'b0);
        xfer("rst_rd04", 1'b0, 32'h04, 32'h0, 1'b0, 32'h0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
